// File: rtl/gpio_swled_irq_pkg.sv
// Shared types for the switch/LED GPIO peripheral: data-bus request and
// response structs, register offsets and the bus FSM state encoding.
package gpio_swled_irq_pkg;

  localparam int DBUS_AW = 32;
  localparam int DBUS_DW = 32;

  typedef struct packed {
    logic               req;
    logic               w_en;
    logic [DBUS_AW-1:0] addr;
    logic [DBUS_DW-1:0] w_data;
  } type_dbus2peri_s;

  typedef struct packed {
    logic [DBUS_DW-1:0] r_data;
    logic               ack;
  } type_peri2dbus_s;

  // Register offsets, decoded on addr[7:0].
  typedef enum logic [7:0] {
    REG_SW_DATA     = 8'h00,
    REG_LED_DATA    = 8'h04,
    REG_LED_SET     = 8'h08,
    REG_LED_CLR     = 8'h0C,
    REG_LED_TGL     = 8'h10,
    REG_IRQ_RISE_EN = 8'h14,
    REG_IRQ_FALL_EN = 8'h18,
    REG_IRQ_STATUS  = 8'h1C
  } type_gpswled_regs_e;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_e;

endpackage

// File: rtl/gpio_swled_irq_if.sv
// Data-bus attachment of the GPIO peripheral: address-decoder select,
// request struct and response struct.
//
// Handshake: a request is valid when req & gpio_sel_i. A valid request seen
// while ack is low is accepted at the next clock edge; ack is then high for
// exactly one cycle with r_data registered at that same edge. A request still
// held during the ack cycle is not accepted again, so a held request is acked
// every other cycle. r_data is 0 whenever ack is low.
interface gpio_swled_irq_if;
  import gpio_swled_irq_pkg::*;

  logic            gpio_sel_i;
  type_dbus2peri_s dbus2gpio_i;
  type_peri2dbus_s gpio2dbus_o;

  modport master (output gpio_sel_i, output dbus2gpio_i, input  gpio2dbus_o);
  modport slave  (input  gpio_sel_i, input  dbus2gpio_i, output gpio2dbus_o);
endinterface

// File: rtl/gpio_swled_irq_debounce.sv
// One switch bit: multi-flop synchroniser followed by a stability counter.
// deb only follows the synchronised level after it has differed from deb for
// DEBOUNCE_CYCLES consecutive cycles. chg flags the cycle in which deb will
// flip at the coming edge, so the parent can set edge status on that edge.
module gpio_swled_irq_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic deb,
  output logic chg
);

  localparam int             CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_nxt;
  logic                   deb_q;
  logic                   deb_nxt;
  logic                   sync;

  assign sync = sync_q[SYNC_STAGES-1];
  assign deb  = deb_q;
  assign chg  = (sync != deb_q) && (cnt_q == CNT_MAX);

  // Counter runs only while the synchronised level disagrees with deb.
  always_comb begin
    cnt_nxt = cnt_q;
    deb_nxt = deb_q;
    if (sync == deb_q) begin
      cnt_nxt = '0;
    end else if (cnt_q == CNT_MAX) begin
      deb_nxt = sync;
      cnt_nxt = '0;
    end else begin
      cnt_nxt = cnt_q + CW'(1);
    end
  end

  // Synchroniser shift chain, counter and debounced level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      deb_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      cnt_q  <= cnt_nxt;
      deb_q  <= deb_nxt;
    end
  end

endmodule

// File: rtl/gpio_swled_irq.sv
// Switch/LED GPIO peripheral on the data bus: debounced switch inputs,
// LED register with atomic set/clear/toggle, and rise/fall edge interrupts
// collected in a sticky write-1-to-clear status register.
module gpio_swled_irq
  import gpio_swled_irq_pkg::*;
#(
  parameter int                 NUM_SW          = 16,
  parameter int                 NUM_LED         = 16,
  parameter int                 SYNC_STAGES     = 2,
  parameter int                 DEBOUNCE_CYCLES = 4,
  parameter logic [NUM_LED-1:0] LED_RESET_VAL   = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  gpio_swled_irq_if.slave    bus,
  input  logic [NUM_SW-1:0]  gp_switch_i,
  output logic [NUM_LED-1:0] gp_led_o,
  output logic               irq_o,
  output bus_state_e         state_dbg
);

  type_dbus2peri_s    req_s;
  logic               valid;
  logic [7:0]         addr;
  logic [NUM_SW-1:0]  w_sw;
  logic [NUM_LED-1:0] w_led;

  bus_state_e state_q, state_nxt;
  logic       accept;
  logic       wr;

  logic [NUM_SW-1:0]  deb, chg, rise, fall;
  logic [NUM_LED-1:0] led_q, led_nxt;
  logic [NUM_SW-1:0]  rise_en_q, rise_en_nxt;
  logic [NUM_SW-1:0]  fall_en_q, fall_en_nxt;
  logic [NUM_SW-1:0]  status_q, status_nxt, w1c;
  logic [DBUS_DW-1:0] rd_data, r_data_q;
  logic               unused_bits;

  assign req_s  = bus.dbus2gpio_i;
  assign valid  = req_s.req & bus.gpio_sel_i;
  assign addr   = req_s.addr[7:0];
  assign w_sw   = req_s.w_data[NUM_SW-1:0];
  assign w_led  = req_s.w_data[NUM_LED-1:0];
  assign wr     = accept & req_s.w_en;
  assign unused_bits = ^{req_s.addr[DBUS_AW-1:8], req_s.w_data};

  // One synchroniser/debouncer per switch bit.
  for (genvar i = 0; i < NUM_SW; i++) begin : g_deb
    gpio_swled_irq_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (gp_switch_i[i]),
      .deb  (deb[i]),
      .chg  (chg[i])
    );
  end

  // Bus FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BUS_IDLE;
    else        state_q <= state_nxt;
  end

  // Bus FSM: accept only from IDLE, always spend exactly one cycle in ACK.
  always_comb begin
    state_nxt = state_q;
    accept    = 1'b0;
    case (state_q)
      BUS_IDLE: begin
        if (valid) begin
          accept    = 1'b1;
          state_nxt = BUS_ACK;
        end
      end
      BUS_ACK:  state_nxt = BUS_IDLE;
      default:  state_nxt = BUS_IDLE;
    endcase
  end

  // Register write decode; edge status is set even when a W1C hits the same bit.
  always_comb begin
    led_nxt     = led_q;
    rise_en_nxt = rise_en_q;
    fall_en_nxt = fall_en_q;
    w1c         = '0;
    if (wr) begin
      case (addr)
        REG_LED_DATA:    led_nxt     = w_led;
        REG_LED_SET:     led_nxt     = led_q | w_led;
        REG_LED_CLR:     led_nxt     = led_q & ~w_led;
        REG_LED_TGL:     led_nxt     = led_q ^ w_led;
        REG_IRQ_RISE_EN: rise_en_nxt = w_sw;
        REG_IRQ_FALL_EN: fall_en_nxt = w_sw;
        REG_IRQ_STATUS:  w1c         = w_sw;
        default: ;
      endcase
    end
    rise       = chg & ~deb;
    fall       = chg & deb;
    status_nxt = (status_q & ~w1c) | (rise & rise_en_q) | (fall & fall_en_q);
  end

  // Read mux over pre-edge register values; unused high bits stay 0.
  always_comb begin
    rd_data = '0;
    case (addr)
      REG_SW_DATA:     rd_data[NUM_SW-1:0]  = deb;
      REG_LED_DATA:    rd_data[NUM_LED-1:0] = led_q;
      REG_IRQ_RISE_EN: rd_data[NUM_SW-1:0]  = rise_en_q;
      REG_IRQ_FALL_EN: rd_data[NUM_SW-1:0]  = fall_en_q;
      REG_IRQ_STATUS:  rd_data[NUM_SW-1:0]  = status_q;
      default: ;
    endcase
  end

  // Register file and registered read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q     <= LED_RESET_VAL;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      r_data_q  <= '0;
    end else begin
      led_q     <= led_nxt;
      rise_en_q <= rise_en_nxt;
      fall_en_q <= fall_en_nxt;
      status_q  <= status_nxt;
      r_data_q  <= (accept && !req_s.w_en) ? rd_data : '0;
    end
  end

  assign bus.gpio2dbus_o = '{r_data: r_data_q, ack: (state_q == BUS_ACK)};
  assign gp_led_o        = led_q;
  assign irq_o           = |status_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_gpio_swled_irq.sv
// Directed bench for gpio_swled_irq: a default-parameter instance (with a
// non-zero LED reset value) and a narrow NUM_SW=5/NUM_LED=3 instance.
module tb_gpio_swled_irq;
  import gpio_swled_irq_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [15:0] sw_a;
  logic [4:0]  sw_p;
  logic [15:0] led_a;
  logic [2:0]  led_p;
  logic        irq_a, irq_p;
  bus_state_e  st_a, st_p;

  int total = 0;
  int bad   = 0;

  logic [15:0] led_snap;
  logic        ack_after;

  gpio_swled_irq_if bus_a();
  gpio_swled_irq_if bus_p();

  gpio_swled_irq #(
    .NUM_SW(16), .NUM_LED(16), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
    .LED_RESET_VAL(16'h00A5)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .gp_switch_i(sw_a),
    .gp_led_o(led_a), .irq_o(irq_a), .state_dbg(st_a)
  );

  gpio_swled_irq #(
    .NUM_SW(5), .NUM_LED(3), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
    .LED_RESET_VAL(3'b000)
  ) u_dut_p (
    .clk(clk), .rst_n(rst_n), .bus(bus_p), .gp_switch_i(sw_p),
    .gp_led_o(led_p), .irq_o(irq_p), .state_dbg(st_p)
  );

  // ---------------- driver tasks ----------------
  task automatic bus_idle(input bit prm);
    if (prm) begin
      bus_p.gpio_sel_i  = 1'b0;
      bus_p.dbus2gpio_i = '0;
    end else begin
      bus_a.gpio_sel_i  = 1'b0;
      bus_a.dbus2gpio_i = '0;
    end
  endtask

  // One bus transfer with a bounded wait for ack; also lets ack drop afterwards.
  task automatic xfer(input bit prm, input logic we, input logic [7:0] addr,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output logic acked);
    type_dbus2peri_s r;
    type_peri2dbus_s resp;
    r = '{req: 1'b1, w_en: we, addr: {24'h0, addr}, w_data: wd};
    acked = 1'b0;
    rd    = '0;
    @(negedge clk);
    if (prm) begin bus_p.gpio_sel_i = 1'b1; bus_p.dbus2gpio_i = r; end
    else     begin bus_a.gpio_sel_i = 1'b1; bus_a.dbus2gpio_i = r; end
    for (int k = 0; k < 4 && !acked; k++) begin
      @(posedge clk); #1;
      resp = prm ? bus_p.gpio2dbus_o : bus_a.gpio2dbus_o;
      if (resp.ack) begin
        acked    = 1'b1;
        rd       = resp.r_data;
        led_snap = prm ? {13'h0, led_p} : led_a;
      end
    end
    bus_idle(prm);
    @(posedge clk); #1;
    ack_after = prm ? bus_p.gpio2dbus_o.ack : bus_a.gpio2dbus_o.ack;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] rd;
    logic        ok;
    rst_n = 1'b0;
    sw_a  = '0;
    sw_p  = '0;
    bus_idle(0);
    bus_idle(1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (led_a !== 16'h00A5) begin bad++; $display("FAIL reset_led: got %h want %h", led_a, 16'h00A5); end
    total++; if (irq_a !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq_a); end
    total++; if (bus_a.gpio2dbus_o !== '0) begin bad++; $display("FAIL reset_resp: got %h want 0", bus_a.gpio2dbus_o); end
    total++; if (led_p !== 3'b000) begin bad++; $display("FAIL reset_led_p: got %b want 000", led_p); end
    total++; if (st_a !== BUS_IDLE) begin bad++; $display("FAIL reset_state: got %0d want 0", st_a); end
    rst_n = 1'b1;
    xfer(0, 1'b0, REG_SW_DATA, 32'h0, rd, ok);
    total++; if (ok !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL reset_sw_read: got ack=%b data=%h want ack=1 data=0", ok, rd); end
  endtask

  task automatic test_led_ops();
    logic [7:0]  addr_t [4] = '{REG_LED_DATA, REG_LED_SET, REG_LED_CLR, REG_LED_TGL};
    logic [31:0] data_t [4] = '{32'h00F0, 32'h000F, 32'h0030, 32'h0101};
    logic [15:0] exp_t  [4] = '{16'h00F0, 16'h00FF, 16'h00CF, 16'h01CE};
    logic [31:0] rd;
    logic        ok;
    for (int i = 0; i < 4; i++) begin
      xfer(0, 1'b1, addr_t[i], data_t[i], rd, ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL led_ack[%0d]: got %b want 1", i, ok); end
      total++; if (led_snap !== exp_t[i]) begin bad++; $display("FAIL led_val[%0d]: got %h want %h", i, led_snap, exp_t[i]); end
      total++; if (ack_after !== 1'b0) begin bad++; $display("FAIL led_ack_drop[%0d]: got %b want 0", i, ack_after); end
    end
    xfer(0, 1'b0, REG_LED_SET, 32'h0, rd, ok);
    total++; if (ok !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL led_set_read: got ack=%b data=%h want ack=1 data=0", ok, rd); end
    xfer(0, 1'b0, REG_LED_DATA, 32'h0, rd, ok);
    total++; if (rd !== 32'h01CE) begin bad++; $display("FAIL led_data_read: got %h want 000001ce", rd); end
  endtask

  task automatic test_bus_edges();
    logic [31:0] rd;
    logic        ok;
    logic        exp_ack;
    xfer(0, 1'b0, 8'h40, 32'h0, rd, ok);
    total++; if (ok !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL unmapped_read: got ack=%b data=%h want ack=1 data=0", ok, rd); end
    // request without select
    @(negedge clk);
    bus_a.gpio_sel_i  = 1'b0;
    bus_a.dbus2gpio_i = '{req: 1'b1, w_en: 1'b0, addr: 32'h4, w_data: 32'h0};
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      total++; if (bus_a.gpio2dbus_o.ack !== 1'b0) begin bad++; $display("FAIL nosel_ack[%0d]: got %b want 0", k, bus_a.gpio2dbus_o.ack); end
    end
    // held read of LED_DATA (0x01CE)
    bus_a.gpio_sel_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      exp_ack = (k % 2 == 0);
      total++; if (bus_a.gpio2dbus_o.ack !== exp_ack) begin bad++; $display("FAIL held_ack[%0d]: got %b want %b", k, bus_a.gpio2dbus_o.ack, exp_ack); end
      total++; if (bus_a.gpio2dbus_o.r_data !== (exp_ack ? 32'h01CE : 32'h0)) begin bad++; $display("FAIL held_rdata[%0d]: got %h want %h", k, bus_a.gpio2dbus_o.r_data, exp_ack ? 32'h01CE : 32'h0); end
    end
    bus_idle(0);
    @(posedge clk);
  endtask

  task automatic test_debounce();
    logic [31:0] rd;
    logic        ok;
    logic        exp_irq;
    xfer(0, 1'b1, REG_IRQ_RISE_EN, 32'h0008, rd, ok);
    @(negedge clk);
    sw_a[3] = 1'b1;
    // level sampled at edge 0 reaches deb (and irq) at edge 5
    for (int e = 0; e <= 5; e++) begin
      @(posedge clk); #1;
      exp_irq = (e == 5);
      total++; if (irq_a !== exp_irq) begin bad++; $display("FAIL deb_latency_edge%0d: got %b want %b", e, irq_a, exp_irq); end
    end
    xfer(0, 1'b0, REG_SW_DATA, 32'h0, rd, ok);
    total++; if (rd !== 32'h0008) begin bad++; $display("FAIL deb_sw_data: got %h want 00000008", rd); end
    xfer(0, 1'b0, REG_IRQ_STATUS, 32'h0, rd, ok);
    total++; if (rd !== 32'h0008) begin bad++; $display("FAIL deb_status: got %h want 00000008", rd); end
    // 3-cycle glitch on switch 5
    @(negedge clk);
    sw_a[5] = 1'b1;
    repeat (3) @(negedge clk);
    sw_a[5] = 1'b0;
    repeat (10) @(posedge clk);
    xfer(0, 1'b0, REG_SW_DATA, 32'h0, rd, ok);
    total++; if (rd !== 32'h0008) begin bad++; $display("FAIL deb_glitch: got %h want 00000008", rd); end
  endtask

  task automatic test_irq();
    logic [31:0] rd;
    logic        ok;
    xfer(0, 1'b1, REG_IRQ_RISE_EN, 32'h0, rd, ok);
    xfer(0, 1'b0, REG_IRQ_STATUS, 32'h0, rd, ok);
    total++; if (rd !== 32'h0008 || irq_a !== 1'b1) begin bad++; $display("FAIL irq_en_clear_keeps: got status=%h irq=%b want 00000008/1", rd, irq_a); end
    xfer(0, 1'b1, REG_IRQ_STATUS, 32'h0008, rd, ok);
    total++; if (irq_a !== 1'b0) begin bad++; $display("FAIL irq_w1c: got %b want 0", irq_a); end
    // fall with FALL_EN=0 must not set status
    @(negedge clk);
    sw_a[3] = 1'b0;
    repeat (10) @(posedge clk);
    xfer(0, 1'b0, REG_IRQ_STATUS, 32'h0, rd, ok);
    total++; if (rd !== 32'h0 || irq_a !== 1'b0) begin bad++; $display("FAIL irq_fall_dis: got status=%h irq=%b want 0/0", rd, irq_a); end
    xfer(0, 1'b0, REG_SW_DATA, 32'h0, rd, ok);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL irq_sw_low: got %h want 0", rd); end
    // rise and W1C of the same bit on the same edge: set wins
    xfer(0, 1'b1, REG_IRQ_RISE_EN, 32'h0008, rd, ok);
    @(negedge clk);
    sw_a[3] = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    bus_a.gpio_sel_i  = 1'b1;
    bus_a.dbus2gpio_i = '{req: 1'b1, w_en: 1'b1, addr: {24'h0, REG_IRQ_STATUS}, w_data: 32'h0008};
    @(posedge clk); #1;
    total++; if (bus_a.gpio2dbus_o.ack !== 1'b1) begin bad++; $display("FAIL irq_same_edge_ack: got %b want 1", bus_a.gpio2dbus_o.ack); end
    total++; if (irq_a !== 1'b1) begin bad++; $display("FAIL irq_same_edge_irq: got %b want 1", irq_a); end
    bus_idle(0);
    @(posedge clk);
    xfer(0, 1'b0, REG_IRQ_STATUS, 32'h0, rd, ok);
    total++; if (rd !== 32'h0008) begin bad++; $display("FAIL irq_same_edge_status: got %h want 00000008", rd); end
    // fall with FALL_EN set does set status
    xfer(0, 1'b1, REG_IRQ_STATUS, 32'h0008, rd, ok);
    xfer(0, 1'b1, REG_IRQ_FALL_EN, 32'h0008, rd, ok);
    @(negedge clk);
    sw_a[3] = 1'b0;
    repeat (10) @(posedge clk);
    xfer(0, 1'b0, REG_IRQ_STATUS, 32'h0, rd, ok);
    total++; if (rd !== 32'h0008 || irq_a !== 1'b1) begin bad++; $display("FAIL irq_fall_en: got status=%h irq=%b want 00000008/1", rd, irq_a); end
  endtask

  task automatic test_params();
    logic [31:0] rd;
    logic        ok;
    xfer(1, 1'b1, REG_LED_DATA, 32'h0000FFFF, rd, ok);
    total++; if (ok !== 1'b1 || led_snap !== 16'h0007) begin bad++; $display("FAIL prm_led: got ack=%b led=%h want 1/0007", ok, led_snap); end
    xfer(1, 1'b0, REG_LED_DATA, 32'h0, rd, ok);
    total++; if (rd !== 32'h7) begin bad++; $display("FAIL prm_led_read: got %h want 00000007", rd); end
    xfer(1, 1'b1, REG_IRQ_RISE_EN, 32'hFFFFFFFF, rd, ok);
    xfer(1, 1'b0, REG_IRQ_RISE_EN, 32'h0, rd, ok);
    total++; if (rd !== 32'h1F) begin bad++; $display("FAIL prm_rise_en_read: got %h want 0000001f", rd); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_led_ops();
    test_bus_edges();
    test_debounce();
    test_irq();
    test_params();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpio_swled_irq.md
# gpio_swled_irq

Parametrised switch/LED GPIO peripheral on the data bus, successor to the fixed 16-switch/16-LED block. It adds:
- configurable switch and LED counts;
- input synchronisation and per-bit debounce;
- atomic LED set/clear/toggle;
- rise/fall edge interrupts with a sticky, write-1-to-clear status.

It sits beside the other dbus peripherals and drives one level interrupt to the platform interrupt controller.

## Interface
- NUM_SW, 16: switch inputs, 1..32.
- NUM_LED, 16: LED outputs, 1..32.
- SYNC_STAGES, 2: synchroniser flops per switch, ≥2.
- DEBOUNCE_CYCLES, 4: stable cycles required before the debounced value changes, ≥1.
- LED_RESET_VAL, '0: LED register value after reset, NUM_LED bits.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- gpio_sel_i  in  1  peripheral select from the address decoder.
- dbus2gpio_i  in  type_dbus2peri_s  bus request (req, w_en, addr, w_data).
- gpio2dbus_o  out  type_peri2dbus_s  bus response (r_data, ack).
- gp_switch_i  in  NUM_SW  raw, asynchronous switch levels.
- gp_led_o  out  NUM_LED  LED drive; equals the LED register.
- irq_o  out  1  OR of all IRQ_STATUS bits.

## Operation
Registers are decoded on addr[7:0]. Bits above NUM_SW/NUM_LED read 0 and ignore writes.
- 0x00 SW_DATA (RO): debounced switch levels.
- 0x04 LED_DATA (RW).
- 0x08 LED_SET (WO): LED |= w_data.
- 0x0C LED_CLR (WO): LED &= ~w_data.
- 0x10 LED_TGL (WO): LED ^= w_data.
- 0x14 IRQ_RISE_EN (RW).
- 0x18 IRQ_FALL_EN (RW).
- 0x1C IRQ_STATUS (RW1C).

Write-only registers read 0. Unmapped offsets read 0 and ignore writes, but are still acked.

Debounce, per bit:
- cnt is the bit's counter, deb its debounced value, sync the synchroniser output.
- If sync == deb: cnt <= 0.
- Else if cnt == DEBOUNCE_CYCLES-1: deb <= sync and cnt <= 0.
- Else: cnt <= cnt+1.
- cnt width is $clog2(DEBOUNCE_CYCLES+1).

Interrupts:
- A rise is deb 0->1; a fall is deb 1->0.
- On the edge where deb changes, status[i] is set if rise&RISE_EN[i] or fall&FALL_EN[i].
- Clearing an enable does not clear status.
- If a set and a W1C of the same bit fall on the same edge, the set wins.

## Timing
- Reset (async): every flop goes to 0, except the LED register, which goes to LED_RESET_VAL. This clears synchronisers, counters, deb, enables, status, ack and r_data. So gp_led_o=LED_RESET_VAL, irq_o=0, ack=0.
- Reset asserted mid-debounce discards partial counts.
- A request is valid when req & gpio_sel_i. No response is given if gpio_sel_i=0.
- Handshake: a valid request with ack low is accepted at the next edge. ack is high for exactly one cycle after that edge, with r_data registered at the same edge. A request still held while ack is high is not re-accepted, so a held request is acked every other cycle.
- Writes update registers at the accepting edge. gp_led_o changes the cycle ack rises.
- r_data holds 0 in every cycle where ack is low.
- Switch latency: a level sampled at edge 0 reaches sync at edge SYNC_STAGES-1 and deb at edge SYNC_STAGES+DEBOUNCE_CYCLES-1, if held throughout. IRQ_STATUS and irq_o update on that same edge.
- A glitch shorter than DEBOUNCE_CYCLES synchronised cycles never changes deb.
- A read of SW_DATA or IRQ_STATUS returns the value present before the accepting edge.

## Structure
- Add to gpio_defs.svh: enum type_gpswled_regs_e with the offsets above. Reuse the existing type_dbus2peri_s / type_peri2dbus_s.
- Sub-module gpio_debounce holds one bit's synchroniser, counter and deb, with parameters SYNC_STAGES and DEBOUNCE_CYCLES. The block instantiates NUM_SW copies in a generate loop.
- Top level holds the register file, bus FSM (IDLE/ACK), edge detect and irq OR.

## Test plan
- Reset: hold rst_n=0 with LED_RESET_VAL=16'h00A5 -> gp_led_o=0x00A5, irq_o=0, ack=0, SW_DATA reads 0 after release.
- LED ops: write LED_DATA=0x00F0, then SET 0x000F, CLR 0x0030, TGL 0x0101 -> gp_led_o 0x00F0, 0x00FF, 0x00CF, 0x01CE. Each write gets a one-cycle ack; reading LED_SET returns 0.
- Debounce (defaults): set switch 3 high at edge 0 and hold -> SW_DATA=0x0008 from edge 5. A 3-cycle pulse on switch 5 never appears.
- IRQ: RISE_EN=0x0008, FALL_EN=0 -> switch 3 rises, then IRQ_STATUS=0x0008 and irq_o=1. The fall does not set status. W1C 0x0008 clears it, and a same-edge new rise keeps the bit set.
- Bus edges: read 0x40 -> 0 with ack. req with gpio_sel_i=0 -> no ack. A held read request -> ack pattern 1,0,1,0.
- Params: NUM_SW=5, NUM_LED=3 -> write LED_DATA=0xFFFF gives gp_led_o=3'b111 and LED_DATA reads 0x7.
